// File: rtl/fixedp_pkg.sv
// Shared definitions for the sign-magnitude fixed-point datapath:
// FSM state encoding, the canonical zero word and the zero-sign rule.
package fixedp_pkg;

    localparam logic ST_ACC  = 1'b0;
    localparam logic ST_HOLD = 1'b1;

    // Canonical +0; slice to the word width in use (widths up to 64).
    localparam logic [63:0] SM_ZERO = '0;

    // A zero magnitude is always emitted with sign 0, so -0 never propagates.
    function automatic logic sm_sign_norm(input logic sign, input logic mag_nonzero);
        return sign & mag_nonzero;
    endfunction

endpackage

// File: rtl/fixedp_sat_add.sv
// Combinational saturating sign-magnitude adder; operands and result
// follow the canonical-zero rule (-0 is read as +0 and never produced).
module fixedp_sat_add
    import fixedp_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] c,
    output logic         ovf
);

    logic [N-2:0] w_ma;
    logic [N-2:0] w_mb;
    logic [N-2:0] w_mag;
    logic [N-1:0] w_sum;
    logic         w_sa;
    logic         w_sb;
    logic         w_sign;

    always_comb begin
        w_ma   = a[N-2:0];
        w_mb   = b[N-2:0];
        w_sa   = sm_sign_norm(a[N-1], |w_ma);
        w_sb   = sm_sign_norm(b[N-1], |w_mb);
        w_sum  = {1'b0, w_ma} + {1'b0, w_mb};
        w_mag  = '0;
        w_sign = 1'b0;
        ovf    = 1'b0;
        if (w_sa == w_sb) begin
            w_sign = w_sa;
            if (w_sum[N-1]) begin
                w_mag = '1;
                ovf   = 1'b1;
            end else begin
                w_mag = w_sum[N-2:0];
            end
        end else if (w_ma >= w_mb) begin
            // Equal magnitudes land here and give zero, fixed to +0 below.
            w_mag  = w_ma - w_mb;
            w_sign = w_sa;
        end else begin
            w_mag  = w_mb - w_ma;
            w_sign = w_sb;
        end
        c = {sm_sign_norm(w_sign, |w_mag), w_mag};
    end

endmodule

// File: rtl/fixedp_accum.sv
// Frame accumulator: sums LEN sign-magnitude samples per frame, then holds
// the saturated total with a sticky saturation flag until it is taken.
module fixedp_accum
    import fixedp_pkg::*;
#(
    parameter int Q   = 15,
    parameter int N   = 32,
    parameter int LEN = 16,
    parameter int CW  = $clog2(LEN) + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    input  logic         in_sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic         out_sat
);

    if (LEN < 1 || Q < 0 || Q > N - 1) begin : g_bad_cfg
        $error("fixedp_accum: LEN must be >= 1 and Q must lie in 0..N-1");
    end

    logic          r_state;
    logic          w_state_nxt;
    logic          r_rdy;
    logic [N-1:0]  r_acc;
    logic [CW-1:0] r_cnt;
    logic          r_sat;

    logic [N-1:0]  w_b;
    logic [N-1:0]  w_sum;
    logic          w_ovf;
    logic          w_in_fire;
    logic          w_out_fire;
    logic          w_last;

    // Subtract mode flips the operand sign; the adder treats a resulting -0 as +0.
    assign w_b        = {in_data[N-1] ^ in_sub, in_data[N-2:0]};
    assign w_last     = (r_cnt == CW'(LEN - 1));
    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;

    fixedp_sat_add #(.N(N)) u_sat_add (
        .a   (r_acc),
        .b   (w_b),
        .c   (w_sum),
        .ovf (w_ovf)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_ACC;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_ACC:  if (w_in_fire && w_last) w_state_nxt = ST_HOLD;
            ST_HOLD: if (w_out_fire)          w_state_nxt = ST_ACC;
            default: w_state_nxt = ST_ACC;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            ST_ACC:  in_ready  = r_rdy;
            ST_HOLD: out_valid = 1'b1;
            default: ;
        endcase
    end

    // rdy keeps in_ready low during reset and for the first edge after it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_rdy <= 1'b0;
        else     r_rdy <= 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= SM_ZERO[N-1:0];
            r_cnt <= '0;
            r_sat <= 1'b0;
        end else if (w_in_fire) begin
            r_acc <= w_sum;
            r_cnt <= r_cnt + CW'(1);
            r_sat <= r_sat | w_ovf;
        end else if (w_out_fire) begin
            r_acc <= SM_ZERO[N-1:0];
            r_cnt <= '0;
            r_sat <= 1'b0;
        end
    end

    assign out_data = r_acc;
    assign out_sat  = r_sat;

endmodule

// File: tb/tb_fixedp_accum.sv
// Self-checking bench for fixedp_accum: three instances (LEN 4, 2, 1) against
// an integer-arithmetic model of the saturating sign-magnitude frame sum.
module tb_fixedp_accum;

    localparam longint MAXM = 64'h7FFF_FFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid  [3];
    logic        in_ready  [3];
    logic [31:0] in_data   [3];
    logic        in_sub    [3];
    logic        out_valid [3];
    logic        out_ready [3];
    logic [31:0] out_data  [3];
    logic        out_sat   [3];

    int     n_checks = 0;
    int     n_errors = 0;
    longint m_acc [3];
    bit     m_sat [3];

    always #5 clk = ~clk;

    fixedp_accum #(.Q(15), .N(32), .LEN(4)) u_len4 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0]), .in_sub(in_sub[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .out_data(out_data[0]), .out_sat(out_sat[0]));

    fixedp_accum #(.Q(15), .N(32), .LEN(2)) u_len2 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1]), .in_sub(in_sub[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .out_data(out_data[1]), .out_sat(out_sat[1]));

    fixedp_accum #(.Q(15), .N(32), .LEN(1)) u_len1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_data(in_data[2]), .in_sub(in_sub[2]), .out_valid(out_valid[2]),
        .out_ready(out_ready[2]), .out_data(out_data[2]), .out_sat(out_sat[2]));

    function automatic longint sm_val(input logic [31:0] w);
        longint m;
        m = longint'(w[30:0]);
        return w[31] ? -m : m;
    endfunction

    function automatic logic [31:0] val_sm(input longint v);
        logic [31:0] r;
        if (v < 0) r = {1'b1, 31'(-v)};
        else       r = {1'b0, 31'(v)};
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_add(input int d, input logic [31:0] data, input logic sub);
        longint s;
        s = m_acc[d] + sm_val({data[31] ^ sub, data[30:0]});
        if (s > MAXM) begin
            s = MAXM;
            m_sat[d] = 1'b1;
        end else if (s < -MAXM) begin
            s = -MAXM;
            m_sat[d] = 1'b1;
        end
        m_acc[d] = s;
    endtask

    // Called and returns at posedge+1; the sample is accepted on the edge in between.
    task automatic push(input int d, input logic [31:0] data, input logic sub);
        int k = 0;
        in_valid[d] = 1'b1;
        in_data[d]  = data;
        in_sub[d]   = sub;
        while (in_ready[d] !== 1'b1 && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        if (in_ready[d] !== 1'b1) begin
            n_checks++;
            n_errors++;
            $error("FAIL push_timeout: in_ready[%0d] observed %b expected 1", d, in_ready[d]);
        end else begin
            @(posedge clk); #1;
            model_add(d, data, sub);
        end
        in_valid[d] = 1'b0;
    endtask

    task automatic check_out(input int d, input string tag);
        check({tag, "_valid"}, 32'(out_valid[d]), 32'd1);
        check({tag, "_ready"}, 32'(in_ready[d]), 32'd0);
        check({tag, "_data"}, out_data[d], val_sm(m_acc[d]));
        check({tag, "_sat"}, 32'(out_sat[d]), 32'(m_sat[d]));
    endtask

    task automatic pop(input int d, input string tag);
        out_ready[d] = 1'b1;
        @(posedge clk); #1;
        out_ready[d] = 1'b0;
        m_acc[d] = 0;
        m_sat[d] = 1'b0;
        check({tag, "_pop_valid"}, 32'(out_valid[d]), 32'd0);
        check({tag, "_pop_ready"}, 32'(in_ready[d]), 32'd1);
        check({tag, "_pop_data"}, out_data[d], 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] hold_data;
        logic        hold_sat;
        logic [31:0] rd;
        int          len;
        int          dd;

        for (int i = 0; i < 3; i++) begin
            in_valid[i] = 1'b0; in_data[i] = '0; in_sub[i] = 1'b0; out_ready[i] = 1'b0;
            m_acc[i] = 0; m_sat[i] = 1'b0;
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(in_ready[0]), 32'd0);
        check("rst_valid", 32'(out_valid[0]), 32'd0);
        check("rst_data", out_data[0], 32'h0);
        check("rst_sat", 32'(out_sat[0]), 32'd0);
        rst = 1'b0;
        #1;
        check("rel_ready_low", 32'(in_ready[0]), 32'd0);
        @(posedge clk); #1;
        check("rel_ready_high", 32'(in_ready[0]), 32'd1);

        // Frame of mixed-sign Q15 values on LEN=4.
        push(0, 32'h0000_8000, 1'b0);
        push(0, 32'h0001_0000, 1'b0);
        push(0, 32'h8000_4000, 1'b0);
        check("t1_not_yet_valid", 32'(out_valid[0]), 32'd0);
        push(0, 32'h0000_2000, 1'b0);
        check_out(0, "t1");
        check("t1_value", out_data[0], 32'h0001_6000);
        pop(0, "t1");

        // Saturation, then a clean frame clears the sticky flag.
        push(1, 32'h7FFF_FFFF, 1'b0);
        push(1, 32'h0000_0001, 1'b0);
        check_out(1, "t2a");
        check("t2a_value", out_data[1], 32'h7FFF_FFFF);
        check("t2a_satflag", 32'(out_sat[1]), 32'd1);
        pop(1, "t2a");
        push(1, 32'h0000_0001, 1'b0);
        push(1, 32'h0000_0001, 1'b0);
        check_out(1, "t2b");
        check("t2b_value", out_data[1], 32'h0000_0002);
        pop(1, "t2b");

        // Cancellation and negative-zero inputs both yield +0.
        push(1, 32'h0000_8000, 1'b0);
        push(1, 32'h8000_8000, 1'b0);
        check_out(1, "t3a");
        check("t3a_value", out_data[1], 32'h0);
        pop(1, "t3a");
        push(1, 32'h8000_0000, 1'b0);
        push(1, 32'h8000_0000, 1'b0);
        check_out(1, "t3b");
        check("t3b_value", out_data[1], 32'h0);
        pop(1, "t3b");

        // Subtract mode.
        push(1, 32'h0000_8000, 1'b0);
        push(1, 32'h0001_0000, 1'b1);
        check_out(1, "t4");
        check("t4_value", out_data[1], 32'h8000_8000);
        pop(1, "t4");

        // Backpressure in HOLD with inputs offered.
        for (int i = 0; i < 4; i++) push(0, $urandom, 1'($urandom_range(0, 1)));
        check_out(0, "t5");
        hold_data = out_data[0];
        hold_sat  = out_sat[0];
        in_valid[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data[0] = $urandom;
            @(posedge clk); #1;
            check("t5_hold_valid", 32'(out_valid[0]), 32'd1);
            check("t5_hold_ready", 32'(in_ready[0]), 32'd0);
            check("t5_hold_data", out_data[0], hold_data);
            check("t5_hold_sat", 32'(out_sat[0]), 32'(hold_sat));
        end
        in_valid[0] = 1'b0;
        pop(0, "t5");
        for (int i = 0; i < 4; i++) push(0, 32'h0000_0003, 1'b0);
        check_out(0, "t5n");
        check("t5n_value", out_data[0], 32'h0000_000C);
        pop(0, "t5n");

        // Reset mid-frame discards the partial sum.
        push(0, 32'h0000_0005, 1'b0);
        push(0, 32'h0000_0005, 1'b0);
        rst = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            m_acc[i] = 0; m_sat[i] = 1'b0;
        end
        check("t6_rst_data", out_data[0], 32'h0);
        check("t6_rst_valid", 32'(out_valid[0]), 32'd0);
        check("t6_rst_ready", 32'(in_ready[0]), 32'd0);
        check("t6_rst_sat", 32'(out_sat[0]), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("t6_rel_ready_low", 32'(in_ready[0]), 32'd0);
        @(posedge clk); #1;
        check("t6_rel_ready_high", 32'(in_ready[0]), 32'd1);
        for (int i = 0; i < 4; i++) push(0, 32'h0000_0001, 1'b0);
        check_out(0, "t6");
        check("t6_value", out_data[0], 32'h0000_0004);
        pop(0, "t6");

        // Randomized frames across LEN = 4, 2, 1.
        for (int it = 0; it < 45; it++) begin
            dd  = it % 3;
            len = (dd == 0) ? 4 : ((dd == 1) ? 2 : 1);
            for (int i = 0; i < len; i++) begin
                rd = $urandom;
                case ($urandom_range(0, 3))
                    0: rd[30:0] = 31'($urandom_range(0, 1000));
                    1: rd[30:0] = '0;
                    2: rd[30:0] = 31'h7FFF_FFFF - 31'($urandom_range(0, 3));
                    default: ;
                endcase
                push(dd, rd, 1'($urandom_range(0, 1)));
            end
            check_out(dd, "rnd");
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
            check("rnd_stable", out_data[dd], val_sm(m_acc[dd]));
            pop(dd, "rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fixedp_accum.md
# fixedp_accum

Frame accumulator for the sign-magnitude fixed-point datapath. It sums a stream of LEN signed samples per frame and presents the saturated total with a sticky saturation flag. Input and output use valid/ready handshakes. It sits behind the detection front end, where the combinational sign-magnitude adder used to be chained by hand. It adds subtract mode, negative-zero normalisation and frame sequencing.

## Interface
- Q, 15, fractional bits (format annotation only; the arithmetic is Q-independent)
- N, 32, word width: bit N-1 is the sign, bits N-2:0 are the magnitude
- LEN, 16, samples per frame, must be ≥1
- CW, $clog2(LEN)+1, frame counter width (derived)

Ports (direction, width, meaning):
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  sample offered
- in_ready  out  1  accumulator can accept a sample
- in_data  in  N  sign-magnitude sample
- in_sub  in  1  when 1, the sample is subtracted instead of added (qualified by in_valid)
- out_valid  out  1  frame total available
- out_ready  in  1  consumer accepts the total
- out_data  out  N  accumulator register (frame total while out_valid=1)
- out_sat  out  1  sticky flag: at least one add in this frame saturated

## Operation
- Number format: sign-magnitude. Magnitude 0 with either sign means zero. The accumulator never holds -0: a zero magnitude is always stored with sign 0.
- Operand b = in_data with its sign bit XORed with in_sub. A -0 result of that flip is treated as +0.
- Add rule, result = sat_add(acc, b):
  - Same signs: magnitude is the sum of magnitudes. If the sum carries out of N-1 bits, magnitude = all ones, sign = common sign, ovf = 1.
  - Different signs: magnitude = larger magnitude minus smaller; sign = sign of the larger.
  - Equal magnitudes with different signs: result is +0.
- FSM has two states, ACC and HOLD, and a separate ready register rdy.
- ACC: in_ready = rdy. On accept (in_valid & in_ready):
  - acc ← sat_add(acc, b)
  - sat ← sat | ovf
  - cnt ← cnt + 1
  - If cnt == LEN-1 on that accept, go to HOLD.
- HOLD: out_valid = 1 and in_ready = 0. in_valid and in_data are ignored. On out_valid & out_ready:
  - acc ← +0, sat ← 0, cnt ← 0
  - go to ACC
- Accumulation continues from a saturated value; only the flag is sticky.
- out_data always shows acc. It is meaningful only while out_valid = 1.

## Timing
- Reset values: state = ACC, rdy = 0, acc = 0, cnt = 0, sat = 0. Outputs during reset: in_ready = 0, out_valid = 0, out_data = 0, out_sat = 0.
- rdy is set on the first rising edge after rst deasserts. From then on in_ready = (state == ACC) & rdy, combinational.
- Throughput: one sample per cycle in ACC.
- Latency: out_valid rises on the edge that accepts the LEN-th sample, so it is visible the following cycle.
- in_ready rises the cycle after the output handshake. A frame therefore takes at least LEN+1 cycles.
- out_data and out_sat are stable for the whole time out_valid = 1 and out_ready = 0.
- LEN = 1: every accept moves directly to HOLD.
- rst asserted mid-frame or in HOLD: state returns to reset values immediately. The partial frame is discarded, and the next frame counts LEN fresh samples.
- There are no simultaneous input and output events, because input is blocked in HOLD.

## Structure
- Shared package fixedp_pkg holds:
  - the state encoding localparams (ST_ACC, ST_HOLD)
  - the sign-magnitude zero constant
  - the convention that a zero magnitude is always emitted with sign 0
- Sub-module fixedp_sat_add (combinational, parameter N):
  - inputs: a, b
  - outputs: c, ovf
  - implements the add rule and -0 normalisation
  - instantiated once; reusable elsewhere in the datapath
- Top level contains only the FSM, the counter, the sticky flag and the handshakes.

## Test plan
1. LEN=4, N=32, Q=15. Add 0x00008000, 0x00010000, 0x80004000, 0x00002000 (values 1.0, 2.0, -0.5, 0.25) → out_data = 0x00016000 (2.75), out_sat = 0, out_valid asserted the cycle after the 4th accept.
2. LEN=2. Add 0x7FFFFFFF, then 0x00000001 → out_data = 0x7FFFFFFF, out_sat = 1. The next frame, 0x00000001 twice, gives 0x00000002 with out_sat = 0.
3. LEN=2. Add 0x00008000, then 0x80008000 → out_data = 0x00000000 (not 0x80000000). Add 0x80000000 then 0x80000000 → 0x00000000.
4. LEN=2. Add 0x00008000, then 0x00010000 with in_sub = 1 → out_data = 0x80008000 (-1.0).
5. Backpressure: out_ready held at 0 for 5 cycles with in_valid = 1 → out_valid stays 1, in_ready stays 0, and out_data/out_sat are unchanged. The held inputs are not counted; the next frame sums only samples accepted after the handshake.
6. Reset mid-frame: LEN=4, accept 2 samples, then pulse rst → all outputs 0 and in_ready returns to 1 one cycle after release. The following 4 samples 0x00000001 produce 0x00000004.
